// File: rtl/demux_unit.sv
// demux_unit: steers a select-tagged input stream into four independent per-lane FIFOs.
// Optional feature: define DEMUX_LANE_COUNT_EN to add the 16-bit per-lane pop counters on lane_count.
`timescale 1ns/1ps
module demux_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic [WIDTH-1:0]   in_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic               err_drop
`ifdef DEMUX_LANE_COUNT_EN
    ,
    output logic [4*16-1:0]    lane_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] push;
    logic [3:0] pop;
    logic       accept;
    logic       err_drop_reg;

    // A full lane can still accept when its head leaves in the same cycle.
    assign in_ready = !full[in_sel] || (out_valid[in_sel] && out_ready[in_sel]);
    assign accept   = in_valid && in_ready;
    assign err_drop = err_drop_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_drop_reg <= 1'b0;
        end else begin
            err_drop_reg <= in_valid && !in_ready;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_lane
            localparam logic [1:0] LANE = 2'(gi);

            logic [PW-1:0]    wptr_reg;
            logic [PW-1:0]    rptr_reg;
            logic [WIDTH-1:0] mem [DEPTH];

            assign empty[gi] = (wptr_reg == rptr_reg);
            assign full[gi]  = (wptr_reg[PW-1] != rptr_reg[PW-1]) &&
                               (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
            assign push[gi]  = accept && (in_sel == LANE);
            assign pop[gi]   = out_valid[gi] && out_ready[gi];

            assign out_valid[gi] = !empty[gi];
            assign out_data[gi*WIDTH +: WIDTH] = empty[gi] ? '0 : mem[rptr_reg[AW-1:0]];

            always_ff @(posedge clk) begin
                if (rst) begin
                    wptr_reg <= '0;
                    rptr_reg <= '0;
                end else begin
                    if (push[gi]) begin
                        wptr_reg <= wptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rptr_reg <= rptr_reg + 1'b1;
                    end
                end
            end

            // Storage needs no reset: empty lanes are masked to zero on out_data.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wptr_reg[AW-1:0]] <= in_data;
                end
            end

`ifdef DEMUX_LANE_COUNT_EN
            logic [15:0] count_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    count_reg <= '0;
                end else if (pop[gi]) begin
                    count_reg <= count_reg + 16'd1;
                end
            end

            assign lane_count[gi*16 +: 16] = count_reg;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_demux_unit.sv
// Directed testbench for demux_unit (WIDTH=8, DEPTH=2) with hand-computed expectations.
`timescale 1ns/1ps
module tb_demux_unit;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        err_drop;
`ifdef DEMUX_LANE_COUNT_EN
    logic [63:0] lane_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    demux_unit #(.WIDTH(8), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_drop  (err_drop)
`ifdef DEMUX_LANE_COUNT_EN
        ,
        .lane_count(lane_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lane(input int k);
        return out_data[k*8 +: 8];
    endfunction

    initial begin
        logic [1:0] sel_tab [4];
        logic [7:0] dat_tab [4];
        sel_tab = '{2'd0, 2'd3, 2'd0, 2'd3};
        dat_tab = '{8'h10, 8'h11, 8'h12, 8'h13};

        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: reset state
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready",  64'(in_ready),  64'h1);
        check("rst_err_drop",  64'(err_drop),  64'h0);
        check("rst_out_data",  64'(out_data),  64'h0);

        // 2: single push to lane 2
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
        #1 check("t2_in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        #1;
        check("t2_out_valid", 64'(out_valid), 64'h4);
        check("t2_out_data",  64'(out_data),  64'h00A5_0000);
        check("t2_err_drop",  64'(err_drop),  64'h0);

        // 3: overfill lane 1, then drain in order
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h01;
        tick();
        in_data = 8'h02;
        tick();
        in_data = 8'h03;
        #1 check("t3_full_in_ready", 64'(in_ready), 64'h0);
        tick();
        check("t3_err_drop",  64'(err_drop),  64'h1);
        check("t3_out_valid", 64'(out_valid), 64'h6);
        check("t3_head0",     64'(lane(1)),   64'h01);
        out_ready = 4'b0010;
        #1 check("t3_pop_in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        #1;
        check("t3_head1",       64'(lane(1)),  64'h02);
        check("t3_err_cleared", 64'(err_drop), 64'h0);
        tick();
        check("t3_head2", 64'(lane(1)), 64'h03);
        tick();
        check("t3_drained_valid", 64'(out_valid), 64'h4);
        check("t3_drained_data",  64'(lane(1)),   64'h00);
        out_ready = 4'b0000;

        // 4: push into a full lane 0 while it pops
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hB0;
        tick();
        in_data = 8'hB1;
        tick();
        in_data = 8'hB2; out_ready = 4'b0001;
        #1 check("t4_in_ready", 64'(in_ready), 64'h1);
        tick();
        check("t4_head", 64'(lane(0)), 64'hB1);
        out_ready = 4'b0000; in_data = 8'hB3;
        #1 check("t4_still_full", 64'(in_ready), 64'h0);
        in_valid = 1'b0; out_ready = 4'b0001;
        tick();
        check("t4_head_next", 64'(lane(0)), 64'hB2);
        tick();
        check("t4_drained", 64'(out_valid), 64'h4);
        out_ready = 4'b0100;
        tick();
        check("t4_lane2_drained", 64'(out_valid), 64'h0);

        // 5: interleaved lanes with all consumers ready
        out_ready = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel = sel_tab[i]; in_data = dat_tab[i];
            tick();
            check($sformatf("t5_valid_%0d", i), 64'(out_valid), 64'(4'b0001 << sel_tab[i]));
            check($sformatf("t5_data_%0d", i),  64'(lane(int'(sel_tab[i]))), 64'(dat_tab[i]));
        end
        in_valid = 1'b0;
        tick();
        check("t5_idle", 64'(out_valid), 64'h0);

        // one-entry lane: simultaneous push and pop replaces the head
        out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h20;
        tick();
        in_data = 8'h21; out_ready = 4'b0001;
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        check("t5_swap_valid", 64'(out_valid), 64'h1);
        check("t5_swap_data",  64'(lane(0)),   64'h21);

        // 6: reset with buffered words
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h31;
        tick();
        in_data = 8'h32;
        tick();
        in_valid = 1'b0;
        #1 check("t6_pre_valid", 64'(out_valid), 64'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6_out_valid", 64'(out_valid), 64'h0);
        check("t6_in_ready",  64'(in_ready),  64'h1);
        check("t6_out_data",  64'(out_data),  64'h0);
        check("t6_err_drop",  64'(err_drop),  64'h0);

`ifdef DEMUX_LANE_COUNT_EN
        check("cnt_after_rst", lane_count, 64'h0);
        out_ready = 4'b0100; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h55;
        tick();
        tick();
        check("cnt_one_pop", lane_count, 64'h0000_0001_0000_0000);
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        check("cnt_wrap", lane_count, 64'h0);
        in_valid = 1'b0; out_ready = 4'b0000;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
